// File: rtl/sound_pwm_dac.sv
`default_nettype none
// ============================================================================
// Module   : sound_pwm_dac
// Purpose  : Converts an unsigned sample stream (sound_generator soundOut)
//            into a 1-bit PWM signal. Duty is latched only at period
//            boundaries, so sample changes never disturb a period in
//            progress. Provides coarse volume (right shift), a clean
//            enable/stop at period boundaries and a period-start strobe.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH     sample / PWM counter width; period = 2^WIDTH ticks
//   PRESCALE  clk cycles per PWM tick (1..65535)
// Ports:
//   clk             system clock
//   rst             synchronous active-low reset
//   en_i            run request (level)
//   sample_i        unsigned sample
//   volume_i        attenuation shift 0..3
//   pwm_o           registered PWM output
//   period_start_o  one-cycle strobe, cycle after a new duty is latched
//   active_o        high while running
// ============================================================================
module sound_pwm_dac #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] sample_i,
  input  logic [1:0]       volume_i,
  output logic             pwm_o,
  output logic             period_start_o,
  output logic             active_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [15:0]      c_presc_last = 16'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] c_cnt_last   = '1;

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_presc, w_presc_nxt;
  logic [WIDTH-1:0] r_cnt,   w_cnt_nxt;
  logic [WIDTH-1:0] r_duty,  w_duty_nxt;
  logic             r_pwm,   w_pwm_nxt;
  logic             r_pstart, w_pstart_nxt;

  logic             w_tick;
  logic             w_boundary;
  logic [WIDTH-1:0] w_shifted;

  assign w_tick     = (r_presc == c_presc_last);
  assign w_boundary = w_tick && (r_cnt == c_cnt_last);
  // Volume attenuation is applied before the latch; a right shift can
  // never overflow the duty register.
  assign w_shifted  = sample_i >> volume_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_presc  <= '0;
      r_cnt    <= '0;
      r_duty   <= '0;
      r_pwm    <= 1'b0;
      r_pstart <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_presc  <= w_presc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_duty   <= w_duty_nxt;
      r_pwm    <= w_pwm_nxt;
      r_pstart <= w_pstart_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_presc_nxt  = r_presc;
    w_cnt_nxt    = r_cnt;
    w_duty_nxt   = r_duty;
    w_pwm_nxt    = 1'b0;
    w_pstart_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_presc_nxt = '0;
        w_cnt_nxt   = '0;
        if (en_i) begin
          w_duty_nxt   = w_shifted;
          w_pstart_nxt = 1'b1;
          w_state_nxt  = ST_RUN;
        end
      end

      ST_RUN: begin
        // Compare uses the pre-edge count, so pwm_o lags cnt by one cycle.
        w_pwm_nxt   = (r_cnt < r_duty);
        w_presc_nxt = w_tick ? 16'd0 : (r_presc + 16'd1);
        if (w_boundary) begin
          w_cnt_nxt = '0;
          if (en_i) begin
            w_duty_nxt   = w_shifted;
            w_pstart_nxt = 1'b1;
          end else begin
            w_duty_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end
        end else if (w_tick) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign pwm_o          = r_pwm;
  assign period_start_o = r_pstart;
  assign active_o       = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_sound_pwm_dac.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_pwm_dac
// Purpose  : Directed self-checking bench for sound_pwm_dac. One instance
//            with PRESCALE=1 covers reset, duty, volume, mid-period change
//            and stop; a second with PRESCALE=4 covers prescaling and reset
//            in the middle of a run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sound_pwm_dac;

  logic       tb_clk = 1'b0;
  logic       rst, en, rst4, en4;
  logic [7:0] smp, smp4;
  logic [1:0] vol;
  logic       pwm, pstart, active;
  logic       pwm4, pstart4, active4;

  int checks = 0;
  int errors = 0;

  always #5 tb_clk = ~tb_clk;

  sound_pwm_dac #(.WIDTH(8), .PRESCALE(1)) u_dut1 (
    .clk(tb_clk), .rst(rst), .en_i(en), .sample_i(smp), .volume_i(vol),
    .pwm_o(pwm), .period_start_o(pstart), .active_o(active)
  );

  sound_pwm_dac #(.WIDTH(8), .PRESCALE(4)) u_dut4 (
    .clk(tb_clk), .rst(rst4), .en_i(en4), .sample_i(smp4), .volume_i(2'd0),
    .pwm_o(pwm4), .period_start_o(pstart4), .active_o(active4)
  );

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at the sample point where period_start is high (cnt=0, new duty
  // latched). Walks the 256 samples of the period: pwm must be high exactly
  // at samples 1..exp_high; the next strobe appears at sample 256 only when
  // the run continues. Optional stimulus changes happen at given samples.
  task automatic run_period(input string tag, input int exp_high, input bit cont,
                            input int chg_at, input logic [7:0] chg_smp, input logic [1:0] chg_vol,
                            input int off_at, input int pulse_at);
    int highs = 0;
    int shape_err = 0;
    int strobe_err = 0;
    check({tag, "_start"}, {31'd0, pstart}, 32'd1);
    for (int i = 1; i <= 256; i++) begin
      step();
      if (pwm) highs++;
      if (pwm !== (i <= exp_high)) shape_err++;
      if (pstart !== ((i == 256) && cont)) strobe_err++;
      if (active !== ((i < 256) || cont)) strobe_err++;
      if (i == chg_at) begin smp = chg_smp; vol = chg_vol; end
      if (i == off_at) en = 1'b0;
      if (i == pulse_at) en = 1'b1;
      if (pulse_at != 0 && i == pulse_at + 1) en = 1'b0;
    end
    check({tag, "_highs"}, highs, exp_high);
    check({tag, "_shape"}, shape_err, 0);
    check({tag, "_strobe"}, strobe_err, 0);
  endtask

  initial begin
    int highs4;
    int shape4;
    int strobe4;

    // Reset held with run requested and full-scale sample.
    rst = 1'b0; en = 1'b1; smp = 8'hFF; vol = 2'd0;
    rst4 = 1'b0; en4 = 1'b0; smp4 = 8'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_pwm", {31'd0, pwm}, 32'd0);
      check("rst_active", {31'd0, active}, 32'd0);
      check("rst_pstart", {31'd0, pstart}, 32'd0);
    end

    // First edge with rst released starts the run.
    rst = 1'b1;
    step();
    check("start_pstart", {31'd0, pstart}, 32'd1);
    check("start_active", {31'd0, active}, 32'd1);
    check("start_pwm", {31'd0, pwm}, 32'd0);

    // Duty 255 (max), queue 64 for next period.
    smp = 8'd64;
    run_period("p255", 255, 1'b1, 0, 8'd0, 2'd0, 0, 0);
    // Duty 64; switch to 128 at cnt=10, must not affect this period.
    run_period("p64", 64, 1'b1, 10, 8'd128, 2'd0, 0, 0);
    // Duty 128; queue 200>>2 = 50.
    run_period("p128", 128, 1'b1, 5, 8'd200, 2'd2, 0, 0);
    run_period("p50", 50, 1'b1, 5, 8'd0, 2'd0, 0, 0);
    // Duty 0; queue 200 unattenuated.
    run_period("p0", 0, 1'b1, 5, 8'd200, 2'd0, 0, 0);
    // Duty 200; drop en at cnt=100, brief re-assert at 150 -> still stops.
    run_period("stop", 200, 1'b0, 0, 8'd0, 2'd0, 100, 150);
    check("stop_active", {31'd0, active}, 32'd0);
    check("stop_pwm", {31'd0, pwm}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_hold", {29'd0, pwm, pstart, active}, 32'd0);
    end

    // PRESCALE=4, sample 3 -> 12 high cycles of a 1024-cycle period.
    rst4 = 1'b1; en4 = 1'b1; smp4 = 8'd3;
    step();
    check("p4_start", {31'd0, pstart4}, 32'd1);
    highs4 = 0; shape4 = 0; strobe4 = 0;
    for (int i = 1; i <= 1024; i++) begin
      step();
      if (pwm4) highs4++;
      if (pwm4 !== (i <= 12)) shape4++;
      if (pstart4 !== (i == 1024)) strobe4++;
    end
    check("p4_highs", highs4, 12);
    check("p4_shape", shape4, 0);
    check("p4_strobe", strobe4, 0);

    // Advance to cnt=2 of the next period (8 cycles), then reset.
    for (int i = 0; i < 8; i++) step();
    check("p4_midrun", {30'd0, pwm4, active4}, 32'd3);
    rst4 = 1'b0;
    step();
    check("p4_rst", {29'd0, pwm4, pstart4, active4}, 32'd0);
    step();
    check("p4_rst_hold", {29'd0, pwm4, pstart4, active4}, 32'd0);
    rst4 = 1'b1; en4 = 1'b0;
    step();
    check("p4_idle", {29'd0, pwm4, pstart4, active4}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sound_pwm_dac.md
Name: sound_pwm_dac

Overview:
- Downstream stage of sound_generator: turns its 8-bit soundOut sample stream into a 1-bit PWM signal for the board speaker/filter.
- Duty is latched only at PWM period boundaries, so sample changes never glitch a period in progress.
- Provides a coarse volume control (right shift), a glitch-free enable/stop, and a period-start strobe for sample-rate alignment.

Parameters:
- WIDTH, 8, sample and PWM counter width; period = 2^WIDTH ticks.
- PRESCALE, 1, clk cycles per PWM tick; legal range 1..65535; 1 means a tick on every cycle.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-low reset
- en_i  input  1  run request; level-sensitive
- sample_i  input  WIDTH  unsigned sample; connects to sound_generator soundOut
- volume_i  input  2  attenuation; effective duty = sample_i >> volume_i (shift 0..3)
- pwm_o  output  1  PWM output, registered
- period_start_o  output  1  one-cycle strobe; asserted in the cycle after a new duty is latched
- active_o  output  1  high while in RUN

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (rst=0 at a posedge):
  - state=IDLE; prescale count=0; cnt=0; duty=0.
  - pwm_o=0, period_start_o=0, active_o=0 after that edge.
  - Reset overrides everything, including mid-period operation.
- Tick: prescale counts 0..PRESCALE-1 and wraps. tick=1 when prescale==PRESCALE-1. With PRESCALE=1, tick is always 1.
- States:
  - IDLE: counters held at 0; pwm_o<=0; active_o=0.
  - RUN: counters advance; active_o=1.
- IDLE -> RUN, when en_i=1 at an edge:
  - cnt<=0, prescale<=0, duty<=sample_i>>volume_i, period_start_o<=1, state<=RUN.
- RUN, every cycle:
  - pwm_o<=(cnt<duty), an unsigned compare. pwm_o therefore lags cnt by one cycle.
  - First possible high pwm_o is the edge after period_start_o rises.
- RUN, on tick with cnt!=2^WIDTH-1: cnt<=cnt+1.
- RUN, period boundary (tick and cnt==2^WIDTH-1):
  - cnt<=0 (wrap); prescale wraps to 0.
  - If en_i=1: duty<=sample_i>>volume_i and period_start_o<=1.
  - If en_i=0: duty<=0, state<=IDLE, period_start_o stays 0.
- period_start_o is 0 in every cycle not listed above; it is never high for two consecutive cycles.
- en_i deasserted mid-period: the current period completes unchanged, then the block stops. pwm_o is 0 from the boundary edge onward. en_i re-asserted before the boundary has no effect.
- sample_i and volume_i: ignored except at latch edges (IDLE->RUN, boundary). Mid-period changes take effect next period.
- Duty limits:
  - duty=0: pwm_o never high.
  - duty=2^WIDTH-1: high for 255 of 256 ticks. 100% duty is not reachable by design.
- High time per period = duty*PRESCALE clk cycles. Period = 2^WIDTH*PRESCALE cycles.
- sample_i and volume_i are sampled at the same edge and the shift is combinational before the latch. No arithmetic overflow is possible.

Test Plan:
- Reset: rst=0 for 2 cycles with en_i=1, sample_i=8'hFF -> pwm_o=0, active_o=0, period_start_o=0 throughout; release rst -> period_start_o pulses 1 cycle after the first edge with rst=1, en_i=1.
- Duty, PRESCALE=1: en_i=1, sample_i=64, volume_i=0 -> per 256-cycle period pwm_o is high exactly 64 consecutive cycles, starting 1 cycle after period_start_o; period_start_o every 256 cycles.
- Volume: sample_i=200, volume_i=2 -> 50 high cycles per period; sample_i=0 -> pwm_o stays 0; sample_i=255, volume_i=0 -> 255 high, 1 low.
- Mid-period change: switch sample_i from 64 to 128 at cnt=10 -> current period still 64 high; the next period is 128 high, starting after the next period_start_o.
- Stop: drop en_i at cnt=100 with duty=200 -> pwm_o keeps its pattern until cnt wraps; then active_o=0, pwm_o=0, no period_start_o. Also pulse en_i 0->1 within the same period -> still stops.
- PRESCALE=4, reset mid-run: sample_i=3 -> 12 high cycles per 1024-cycle period. Assert rst=0 at cnt=2 -> all outputs 0 after the next edge.
